// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU op codes, datapath select values and FSM state numbering.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;

    localparam logic [1:0] SRCB_RD2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ALU_CLS_ADD   = 2'b00,
        ALU_CLS_SUB   = 2'b01,
        ALU_CLS_FUNCT = 2'b10,
        ALU_CLS_NONE  = 2'b11
    } alu_cls_e;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps an ALU class (add / sub / funct-driven / idle) to the 3-bit ALU op
// and flags R-type funct codes the datapath cannot execute.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_cls_e   alu_cls_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic       funct_bad_o
);

    always_comb begin
        alu_op_o    = ALU_NONE;
        funct_bad_o = !((funct_i == FN_ADD) || (funct_i == FN_SUB));
        case (alu_cls_i)
            ALU_CLS_ADD: alu_op_o = ALU_ADD;
            ALU_CLS_SUB: alu_op_o = ALU_SUB;
            ALU_CLS_FUNCT: begin
                if (funct_i == FN_ADD)      alu_op_o = ALU_ADD;
                else if (funct_i == FN_SUB) alu_op_o = ALU_SUB;
            end
            default: alu_op_o = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath and counts retired instructions.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] retired
);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] retired_q;
    logic               retire;
    alu_cls_e           alu_cls;
    logic [2:0]         alu_op_c;
    logic               funct_bad;

    logic       pc_en_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
    logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c, illegal_c;
    logic [1:0] alu_src_b_c, pc_source_c;

    mips_alu_decoder u_alu_dec (
        .alu_cls_i   (alu_cls),
        .funct_i     (funct),
        .alu_op_o    (alu_op_c),
        .funct_bad_o (funct_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + COUNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        alu_cls      = ALU_CLS_NONE;
        pc_en_c      = 1'b0;
        i_or_d_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = SRCB_RD2;
        pc_source_c  = PCSRC_ALU;
        illegal_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                alu_cls     = ALU_CLS_ADD;
                ir_write_c  = mem_ready;
                pc_en_c     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_c = SRCB_IMM_SH2;
                alu_cls     = ALU_CLS_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    OP_RTYPE: begin
                        if (funct_bad) begin
                            illegal_c = 1'b1;
                            state_d   = S_FETCH;
                        end else begin
                            state_d = S_R_EXEC;
                        end
                    end
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                alu_cls     = ALU_CLS_ADD;
                state_d     = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_cls     = ALU_CLS_FUNCT;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_cls     = ALU_CLS_SUB;
                pc_source_c = PCSRC_ALUOUT;
                pc_en_c     = zero;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_source_c = PCSRC_JUMP;
                pc_en_c     = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                alu_cls     = ALU_CLS_ADD;
                state_d     = S_I_WB;
            end
            S_I_WB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // The reset state is FETCH, whose Moore outputs are non-zero, so every
    // control output is gated by rst_n to stay quiet while reset is held.
    assign pc_en      = rst_n & pc_en_c;
    assign i_or_d     = rst_n & i_or_d_c;
    assign mem_read   = rst_n & mem_read_c;
    assign mem_write  = rst_n & mem_write_c;
    assign ir_write   = rst_n & ir_write_c;
    assign reg_dst    = rst_n & reg_dst_c;
    assign mem_to_reg = rst_n & mem_to_reg_c;
    assign reg_write  = rst_n & reg_write_c;
    assign alu_src_a  = rst_n & alu_src_a_c;
    assign illegal    = rst_n & illegal_c;
    assign alu_src_b  = rst_n ? alu_src_b_c : '0;
    assign alu_op     = rst_n ? alu_op_c    : '0;
    assign pc_source  = rst_n ? pc_source_c : '0;

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for the multi-cycle MIPS controller, with
// hand-written sequences for counter wrap and reset during a memory wait.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic [3:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_ctrl #(.COUNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal    (illegal),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // {pc_en,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
    //  alu_src_a, alu_src_b[1:0], alu_op[2:0], pc_source[1:0], illegal}
    logic [16:0] act_ctl;
    assign act_ctl = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal};

    localparam logic [16:0] C_ZERO       = 17'b0_0_0_0_0_0_0_0_0_00_000_00_0;
    localparam logic [16:0] C_FETCH_RDY  = 17'b1_0_1_0_1_0_0_0_0_01_010_00_0;
    localparam logic [16:0] C_FETCH_WAIT = 17'b0_0_1_0_0_0_0_0_0_01_010_00_0;
    localparam logic [16:0] C_DEC        = 17'b0_0_0_0_0_0_0_0_0_11_010_00_0;
    localparam logic [16:0] C_DEC_ILL    = 17'b0_0_0_0_0_0_0_0_0_11_010_00_1;
    localparam logic [16:0] C_MADDR      = 17'b0_0_0_0_0_0_0_0_1_10_010_00_0;
    localparam logic [16:0] C_MRD        = 17'b0_1_1_0_0_0_0_0_0_00_000_00_0;
    localparam logic [16:0] C_MWB        = 17'b0_0_0_0_0_0_1_1_0_00_000_00_0;
    localparam logic [16:0] C_MWR        = 17'b0_1_0_1_0_0_0_0_0_00_000_00_0;
    localparam logic [16:0] C_RADD       = 17'b0_0_0_0_0_0_0_0_1_00_010_00_0;
    localparam logic [16:0] C_RSUB       = 17'b0_0_0_0_0_0_0_0_1_00_110_00_0;
    localparam logic [16:0] C_RWB        = 17'b0_0_0_0_0_1_0_1_0_00_000_00_0;
    localparam logic [16:0] C_BR_T       = 17'b1_0_0_0_0_0_0_0_1_00_110_01_0;
    localparam logic [16:0] C_BR_N       = 17'b0_0_0_0_0_0_0_0_1_00_110_01_0;
    localparam logic [16:0] C_JMP        = 17'b1_0_0_0_0_0_0_0_0_00_000_10_0;
    localparam logic [16:0] C_IEX        = 17'b0_0_0_0_0_0_0_0_1_10_010_00_0;
    localparam logic [16:0] C_IWB        = 17'b0_0_0_0_0_0_0_1_0_00_000_00_0;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [3:0]  ret;
    } vec_t;

    localparam int NROWS = 39;
    vec_t tbl [NROWS];

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic rdy,
                                input logic [3:0] st, input logic [16:0] ctl,
                                input logic [3:0] ret);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.st = st; v.ctl = ctl; v.ret = ret;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [3:0] exp_ret;

    initial begin
        // add, lw (2 wait cycles), sw (1 wait), beq taken/not, sub, addi,
        // illegal opcode, illegal funct, fetch wait then j.
        tbl[0]  = mk(6'h00, 6'h20, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY,  4'd0);
        tbl[1]  = mk(6'h00, 6'h20, 1'b0, 1'b1, 4'd1,  C_DEC,        4'd0);
        tbl[2]  = mk(6'h00, 6'h20, 1'b0, 1'b1, 4'd6,  C_RADD,       4'd0);
        tbl[3]  = mk(6'h00, 6'h20, 1'b0, 1'b1, 4'd7,  C_RWB,        4'd0);
        tbl[4]  = mk(6'h23, 6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY,  4'd1);
        tbl[5]  = mk(6'h23, 6'h00, 1'b0, 1'b1, 4'd1,  C_DEC,        4'd1);
        tbl[6]  = mk(6'h23, 6'h00, 1'b0, 1'b1, 4'd2,  C_MADDR,      4'd1);
        tbl[7]  = mk(6'h23, 6'h00, 1'b0, 1'b0, 4'd3,  C_MRD,        4'd1);
        tbl[8]  = mk(6'h23, 6'h00, 1'b0, 1'b0, 4'd3,  C_MRD,        4'd1);
        tbl[9]  = mk(6'h23, 6'h00, 1'b0, 1'b1, 4'd3,  C_MRD,        4'd1);
        tbl[10] = mk(6'h23, 6'h00, 1'b0, 1'b1, 4'd4,  C_MWB,        4'd1);
        tbl[11] = mk(6'h2B, 6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY,  4'd2);
        tbl[12] = mk(6'h2B, 6'h00, 1'b0, 1'b1, 4'd1,  C_DEC,        4'd2);
        tbl[13] = mk(6'h2B, 6'h00, 1'b0, 1'b1, 4'd2,  C_MADDR,      4'd2);
        tbl[14] = mk(6'h2B, 6'h00, 1'b0, 1'b0, 4'd5,  C_MWR,        4'd2);
        tbl[15] = mk(6'h2B, 6'h00, 1'b0, 1'b1, 4'd5,  C_MWR,        4'd2);
        tbl[16] = mk(6'h04, 6'h00, 1'b1, 1'b1, 4'd0,  C_FETCH_RDY,  4'd3);
        tbl[17] = mk(6'h04, 6'h00, 1'b1, 1'b1, 4'd1,  C_DEC,        4'd3);
        tbl[18] = mk(6'h04, 6'h00, 1'b1, 1'b1, 4'd8,  C_BR_T,       4'd3);
        tbl[19] = mk(6'h04, 6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY,  4'd4);
        tbl[20] = mk(6'h04, 6'h00, 1'b0, 1'b1, 4'd1,  C_DEC,        4'd4);
        tbl[21] = mk(6'h04, 6'h00, 1'b0, 1'b1, 4'd8,  C_BR_N,       4'd4);
        tbl[22] = mk(6'h00, 6'h22, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY,  4'd5);
        tbl[23] = mk(6'h00, 6'h22, 1'b0, 1'b1, 4'd1,  C_DEC,        4'd5);
        tbl[24] = mk(6'h00, 6'h22, 1'b1, 1'b1, 4'd6,  C_RSUB,       4'd5);
        tbl[25] = mk(6'h00, 6'h22, 1'b0, 1'b1, 4'd7,  C_RWB,        4'd5);
        tbl[26] = mk(6'h08, 6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY,  4'd6);
        tbl[27] = mk(6'h08, 6'h00, 1'b0, 1'b1, 4'd1,  C_DEC,        4'd6);
        tbl[28] = mk(6'h08, 6'h00, 1'b0, 1'b0, 4'd10, C_IEX,        4'd6);
        tbl[29] = mk(6'h08, 6'h00, 1'b0, 1'b1, 4'd11, C_IWB,        4'd6);
        tbl[30] = mk(6'h3F, 6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY,  4'd7);
        tbl[31] = mk(6'h3F, 6'h00, 1'b0, 1'b1, 4'd1,  C_DEC_ILL,    4'd7);
        tbl[32] = mk(6'h00, 6'h21, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY,  4'd7);
        tbl[33] = mk(6'h00, 6'h21, 1'b0, 1'b1, 4'd1,  C_DEC_ILL,    4'd7);
        tbl[34] = mk(6'h02, 6'h00, 1'b0, 1'b0, 4'd0,  C_FETCH_WAIT, 4'd7);
        tbl[35] = mk(6'h02, 6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY,  4'd7);
        tbl[36] = mk(6'h02, 6'h00, 1'b0, 1'b0, 4'd1,  C_DEC,        4'd7);
        tbl[37] = mk(6'h02, 6'h00, 1'b0, 1'b1, 4'd9,  C_JMP,        4'd7);
        tbl[38] = mk(6'h02, 6'h00, 1'b0, 1'b0, 4'd0,  C_FETCH_WAIT, 4'd8);

        #1 rst_n = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctl",     32'(act_ctl), 32'(C_ZERO));
        check("rst_state",   32'(state),   32'd0);
        check("rst_retired", 32'(retired), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NROWS; i++) begin
            opcode    = tbl[i].op;
            funct     = tbl[i].fn;
            zero      = tbl[i].z;
            mem_ready = tbl[i].rdy;
            #1;
            check($sformatf("row%0d_state", i),   32'(state),   32'(tbl[i].st));
            check($sformatf("row%0d_ctl", i),     32'(act_ctl), 32'(tbl[i].ctl));
            check($sformatf("row%0d_retired", i), 32'(retired), 32'(tbl[i].ret));
            check($sformatf("row%0d_excl", i),
                  32'((mem_read & mem_write) | (reg_write & mem_write)), 32'd0);
            @(negedge clk);
        end

        // 16 jumps on a 4-bit counter starting at 8: wraps to 0 after the 8th.
        exp_ret = 4'd8;
        opcode  = 6'h02;
        for (int k = 0; k < 16; k++) begin
            mem_ready = 1'b1;
            #1;
            check($sformatf("j%0d_fetch", k),   32'(state),   32'd0);
            check($sformatf("j%0d_retired", k), 32'(retired), 32'(exp_ret));
            @(negedge clk); #1;
            check($sformatf("j%0d_decode", k),  32'(state),   32'd1);
            @(negedge clk); #1;
            check($sformatf("j%0d_jstate", k),  32'(state),   32'd9);
            check($sformatf("j%0d_jctl", k),    32'(act_ctl), 32'(C_JMP));
            @(negedge clk);
            exp_ret = exp_ret + 4'd1;
            if (k == 7) begin
                #1 check("wrap_to_zero", 32'(retired), 32'd0);
            end
        end
        #1 check("wrap_final", 32'(retired), 32'd8);

        // sw stalled in MEM_WR, then asynchronous reset mid-wait.
        opcode    = 6'h2B;
        mem_ready = 1'b1;
        @(negedge clk); #1;
        check("sw_decode", 32'(state), 32'd1);
        @(negedge clk); #1;
        check("sw_maddr", 32'(state), 32'd2);
        mem_ready = 1'b0;
        @(negedge clk); #1;
        check("sw_wait_state", 32'(state),   32'd5);
        check("sw_wait_ctl",   32'(act_ctl), 32'(C_MWR));
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctl",     32'(act_ctl), 32'(C_ZERO));
        check("arst_state",   32'(state),   32'd0);
        check("arst_retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("post_rst%0d_state", c), 32'(state),     32'd0);
            check($sformatf("post_rst%0d_ctl", c),   32'(act_ctl),   32'(C_FETCH_WAIT));
            check($sformatf("post_rst%0d_mw", c),    32'(mem_write), 32'd0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
